// File: rtl/mlp_axis_endpoint.sv
// AXI-Stream tile model behind the MLP NoC link: buffers single-flit packets, accumulates INPUT
// vectors lane-wise and returns snapshots on INSTR. Define MLP_ENDPOINT_SAT_EN for signed saturation.
module mlp_axis_endpoint #(
  parameter int unsigned    DATAW      = 128,
  parameter int unsigned    IDW        = 4,
  parameter int unsigned    DESTW      = 12,
  parameter int unsigned    USERW      = 75,
  parameter int unsigned    LANES      = 8,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter logic [IDW-1:0] NODE_ID    = 4'h1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [DATAW-1:0] s_tdata,
  input  logic             s_tlast,
  input  logic [IDW-1:0]   s_tid,
  input  logic [USERW-1:0] s_tuser,
  input  logic [DESTW-1:0] s_tdest,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DATAW-1:0] m_tdata,
  output logic             m_tlast,
  output logic [IDW-1:0]   m_tid,
  output logic [USERW-1:0] m_tuser,
  output logic [DESTW-1:0] m_tdest,
  output logic             busy,
  output logic [7:0]       drop_count
);

  localparam int unsigned      LW       = DATAW / LANES;
  localparam int unsigned      AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]      FifoFull = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0]       OpInstr  = 2'b00;
  localparam logic [1:0]       OpInput  = 2'b01;
  localparam logic [USERW-1:0] RespUser = USERW'(2'b01) << 9;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q;
  logic [DATAW-1:0] acc_q;

  logic [DATAW+1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  logic             accept, flit_ok, push, pop;
  logic [1:0]       pop_op;
  logic [DATAW-1:0] pop_data;

  // Per-lane add; the saturating build treats each lane as signed two's complement.
  function automatic logic [DATAW-1:0] lane_add(input logic [DATAW-1:0] a,
                                                input logic [DATAW-1:0] b);
    logic [DATAW-1:0] r;
`ifdef MLP_ENDPOINT_SAT_EN
    logic [LW:0] s;
`endif
    r = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef MLP_ENDPOINT_SAT_EN
      s = {a[i*LW+LW-1], a[i*LW +: LW]} + {b[i*LW+LW-1], b[i*LW +: LW]};
      if (s[LW] != s[LW-1]) begin
        r[i*LW +: LW] = s[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
      end else begin
        r[i*LW +: LW] = s[LW-1:0];
      end
`else
      r[i*LW +: LW] = a[i*LW +: LW] + b[i*LW +: LW];
`endif
    end
    return r;
  endfunction

  assign s_tready = (count_q != FifoFull);
  assign accept   = s_tvalid && s_tready;
  assign flit_ok  = (s_tdest[3:0] == NODE_ID[3:0]) && !s_tuser[10];
  assign push     = accept && flit_ok;
  assign pop      = (state_q == StIdle) && (count_q != '0);
  assign {pop_op, pop_data} = fifo_mem_q[rd_ptr_q];

  assign m_tid = NODE_ID;
  assign busy  = (count_q != '0) || (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {s_tuser[10:9], s_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (AW+1)'(1);
      end
      if (accept && !flit_ok && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tdest  <= '0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            unique case (pop_op)
              OpInput: acc_q <= lane_add(acc_q, pop_data);
              OpInstr: begin
                // Snapshot takes the pre-clear value, so CLEAR+SEND returns the old sum.
                if (pop_data[1]) begin
                  m_tvalid <= 1'b1;
                  m_tdata  <= acc_q;
                  m_tdest  <= DESTW'(pop_data[13:2]);
                  m_tuser  <= RespUser;
                  m_tlast  <= 1'b1;
                  state_q  <= StSend;
                end
                if (pop_data[0]) begin
                  acc_q <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        StSend: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{s_tlast, s_tid, s_tuser[USERW-1:11], s_tuser[8:0], s_tdest[DESTW-1:4]};

endmodule

// File: tb/tb_mlp_axis_endpoint.sv
// Scoreboard bench for mlp_axis_endpoint: directed scenarios plus randomized traffic checked
// against a lane-array reference model.
`timescale 1ns/1ps
module tb_mlp_axis_endpoint;

  localparam logic [3:0]  NODE      = 4'h1;
  localparam logic [74:0] RESP_USER = 75'h200;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s_tvalid, s_tready, s_tlast;
  logic [127:0] s_tdata;
  logic [3:0]   s_tid;
  logic [74:0]  s_tuser;
  logic [11:0]  s_tdest;
  logic         m_tvalid, m_tready, m_tlast;
  logic [127:0] m_tdata;
  logic [3:0]   m_tid;
  logic [74:0]  m_tuser;
  logic [11:0]  m_tdest;
  logic         busy;
  logic [7:0]   drop_count;

  always #5 clk = ~clk;

  mlp_axis_endpoint dut (
    .clk(clk), .reset_n(reset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tid(s_tid), .s_tuser(s_tuser), .s_tdest(s_tdest),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tuser(m_tuser), .m_tdest(m_tdest),
    .busy(busy), .drop_count(drop_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_ready = 1'b0;

  // Reference model: eight 16-bit lanes held as plain integers 0..65535.
  int           acc_m [8];
  int           drop_m = 0;
  logic [127:0] exp_data_q [$];
  logic [11:0]  exp_dest_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic int lane_sum(input int a, input int b);
`ifdef MLP_ENDPOINT_SAT_EN
    int sa, sb, s;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    s  = sa + sb;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s & 32'hFFFF;
`else
    return (a + b) % 65536;
`endif
  endfunction

  function automatic logic [127:0] pack_acc();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = acc_m[i][15:0];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) acc_m[i] = 0;
    drop_m = 0;
    exp_data_q.delete();
    exp_dest_q.delete();
  endfunction

  function automatic void model_accept(input logic [127:0] d, input logic [1:0] op,
                                       input logic [3:0] dst);
    if (dst != NODE || op[1]) begin
      if (drop_m < 255) drop_m++;
    end else if (op == 2'b01) begin
      for (int i = 0; i < 8; i++) acc_m[i] = lane_sum(acc_m[i], int'(d[i*16 +: 16]));
    end else begin
      if (d[1]) begin
        exp_data_q.push_back(pack_acc());
        exp_dest_q.push_back(d[13:2]);
      end
      if (d[0]) for (int i = 0; i < 8; i++) acc_m[i] = 0;
    end
  endfunction

  function automatic logic [127:0] rand_lanes();
    logic [127:0] v;
    logic [15:0]  l;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0:       l = 16'h7FFF;
        1:       l = 16'h8000;
        2:       l = 16'hFFFF;
        default: l = 16'($urandom_range(0, 65535));
      endcase
      v[i*16 +: 16] = l;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  // Offers one flit for up to max_wait cycles; the model sees it only if it was accepted.
  task automatic send_flit(input logic [127:0] d, input logic [1:0] op, input logic [3:0] dst,
                           input int max_wait, output bit ok);
    logic [95:0] r;
    r        = {$urandom, $urandom, $urandom};
    ok       = 1'b0;
    s_tdata  = d;
    s_tuser  = r[74:0];
    s_tuser[10:9] = op;
    s_tdest  = {8'($urandom), dst};
    s_tid    = 4'($urandom);
    s_tlast  = 1'($urandom);
    s_tvalid = 1'b1;
    for (int w = 0; w < max_wait && !ok; w++) begin
      @(negedge clk);
      ok = s_tready;
      tick();
    end
    s_tvalid = 1'b0;
    if (ok) model_accept(d, op, dst);
  endtask

  task automatic input_flit(input logic [127:0] d);
    bit ok;
    send_flit(d, 2'b01, NODE, 200, ok);
    if (!ok) timeout("input_handshake");
  endtask

  task automatic instr(input bit clr, input bit snd, input logic [11:0] dest);
    bit ok;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, 18'($urandom), dest, snd, clr};
    send_flit(d, 2'b00, NODE, 200, ok);
    if (!ok) timeout("instr_handshake");
  endtask

  task automatic bad_flit();
    bit ok;
    if ($urandom_range(0, 1) == 0)
      send_flit(rand_lanes(), 2'($urandom_range(0, 1)), NODE + 4'($urandom_range(1, 15)), 200, ok);
    else
      send_flit(rand_lanes(), 2'($urandom_range(2, 3)), NODE, 200, ok);
    if (!ok) timeout("bad_handshake");
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int w = 0; w < 1000 && !done; w++) begin
      @(negedge clk);
      done = (busy === 1'b0) && (m_tvalid === 1'b0);
      tick();
    end
    if (!done) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    bit done = 1'b0;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      done = (m_tvalid === 1'b1);
      tick();
    end
    if (!done) timeout(name);
  endtask

  // Monitor: every cycle a response is presented it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && m_tvalid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_response: got m_tdata 0x%0h, expected no response", m_tdata);
      end else begin
        check("resp_data", m_tdata, exp_data_q[0]);
        check("resp_dest", 128'(m_tdest), 128'(exp_dest_q[0]));
        check("resp_side", 128'({m_tlast, m_tid, m_tuser}), 128'({1'b1, NODE, RESP_USER}));
        if (m_tready === 1'b1) begin
          void'(exp_data_q.pop_front());
          void'(exp_dest_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int accepted;
    bit ok;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tdest = '0; s_tid = '0; s_tlast = 1'b0;
    m_tready = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    repeat (3) tick();
    @(negedge clk);
    check("rst_m_tdata", m_tdata, 128'h0);
    check("rst_outputs", 128'({m_tvalid, m_tlast, m_tid, m_tuser, m_tdest, busy, drop_count}),
          128'({1'b0, 1'b0, NODE, 75'h0, 12'h0, 1'b0, 8'h0}));
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_s_tready", 128'(s_tready), 128'(1));
    tick();

    // Accumulate and return, with response latency.
    input_flit({8{16'h0001}});
    d = '0;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(i);
    input_flit(d);
    instr(1'b0, 1'b1, 12'd5);
    @(negedge clk);
    check("latency_e0", 128'(m_tvalid), 128'(0));
    tick();
    @(negedge clk);
    check("latency_e1", 128'(m_tvalid), 128'(1));
    tick();
    m_tready = 1'b1;
    wait_idle("accumulate_idle");

    // Lane overflow at the signed boundary and at the unsigned wrap.
    instr(1'b1, 1'b0, 12'd0);
    input_flit(128'h7FFF);
    input_flit(128'h0001);
    instr(1'b1, 1'b1, 12'd3);
    input_flit(128'hFFFF);
    input_flit(128'h0002);
    instr(1'b1, 1'b1, 12'd4);
    wait_idle("overflow_idle");

    // Backpressure: response stalled, ingress fills to depth.
    m_tready = 1'b0;
    instr(1'b0, 1'b1, 12'd7);
    wait_valid("bp_valid");
    repeat (12) tick();
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      send_flit(rand_lanes(), 2'b01, NODE, 3, ok);
      if (!ok) break;
      accepted++;
    end
    check("bp_accepted", 128'(accepted), 128'(4));
    @(negedge clk);
    check("bp_tready_low", 128'(s_tready), 128'(0));
    tick();
    m_tready = 1'b1;
    for (int k = accepted; k < 6; k++) input_flit(rand_lanes());
    wait_idle("bp_drain");
    @(negedge clk);
    check("bp_tready_back", 128'(s_tready), 128'(1));
    tick();
    instr(1'b1, 1'b1, 12'd8);
    wait_idle("bp_result");

    // Drops leave the accumulator alone and saturate the counter.
    input_flit(rand_lanes());
    send_flit(rand_lanes(), 2'b01, NODE + 4'd1, 50, ok);
    send_flit(rand_lanes(), 2'b10, NODE, 50, ok);
    @(negedge clk);
    check("drop_two", 128'(drop_count), 128'(drop_m));
    check("drop_two_model", 128'(drop_m), 128'(2));
    tick();
    instr(1'b0, 1'b1, 12'd9);
    repeat (260) bad_flit();
    @(negedge clk);
    check("drop_saturate", 128'(drop_count), 128'(8'hFF));
    tick();
    wait_idle("drop_idle");

    // CLEAR+SEND returns the old sum; the follow-up SEND sees zero.
    instr(1'b1, 1'b0, 12'd0);
    input_flit({8{16'h0003}});
    instr(1'b1, 1'b1, 12'd10);
    instr(1'b0, 1'b1, 12'd11);
    wait_idle("clear_send_idle");

    // Reset while a response is stalled.
    input_flit(rand_lanes());
    m_tready = 1'b0;
    instr(1'b0, 1'b1, 12'd12);
    wait_valid("rst_mid_valid");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_mid_outputs", 128'({m_tvalid, busy, s_tready, drop_count}),
          128'({1'b0, 1'b0, 1'b1, 8'h0}));
    tick();
    m_tready = 1'b1;
    instr(1'b0, 1'b1, 12'd13);
    wait_idle("rst_mid_idle");

    // Randomized traffic with random response backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: input_flit(rand_lanes());
        6, 7, 8: instr(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 12'($urandom));
        default: bad_flit();
      endcase
    end
    rand_ready = 1'b0;
    m_tready   = 1'b1;
    wait_idle("random_idle");
    check("random_drops", 128'(drop_count), 128'(drop_m));
    check("scoreboard_empty", 128'(exp_data_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
